// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard slice.
package reg_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int SB_CNT_W   = 2;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  localparam sb_cnt_t SB_CNT_MAX = '1;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / kill bundle between the pipeline and the scoreboard.
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32
);

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_reg_write;
  logic [REG_ADDR_W-1:0] issue_rs1;
  logic [REG_ADDR_W-1:0] issue_rs2;
  logic                  issue_use_rs1;
  logic                  issue_use_rs2;
  logic                  issue_stall;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_reg_write;
  logic                  kill_valid;
  logic [REG_ADDR_W-1:0] kill_rd;
  logic                  kill_reg_write;
  logic [NUM_REGS-1:0]   busy_vec;
  logic [7:0]            outstanding;
  logic                  sb_err;

  modport master (
    output issue_valid, issue_rd, issue_reg_write, issue_rs1, issue_rs2,
           issue_use_rs1, issue_use_rs2,
           wb_valid, wb_rd, wb_reg_write,
           kill_valid, kill_rd, kill_reg_write,
    input  issue_stall, busy_vec, outstanding, sb_err
  );

  modport slave (
    input  issue_valid, issue_rd, issue_reg_write, issue_rs1, issue_rs2,
           issue_use_rs1, issue_use_rs2,
           wb_valid, wb_rd, wb_reg_write,
           kill_valid, kill_rd, kill_reg_write,
    output issue_stall, busy_vec, outstanding, sb_err
  );

endinterface

// File: rtl/reg_scoreboard_entry.sv
// One per-register pending-write counter with clamp-at-zero underflow detection.
module sb_entry
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             zero_next,
  output logic             underflow
);

  logic [CNT_W:0] up;
  logic [CNT_W:0] dn;

  assign up = {1'b0, cnt} + (CNT_W+1)'(inc);
  assign dn = (CNT_W+1)'(dec_wb) + (CNT_W+1)'(dec_kill);

  // Ignores inc on purpose: the issue stall reads this, and inc depends on the stall.
  assign zero_next = ({1'b0, cnt} == dn);

  assign underflow = (dn > up);
  assign cnt_next  = underflow ? '0 : CNT_W'(up - dn);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_next;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard at ID/EX; stalls issue on RAW or counter-full hazards.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = SB_CNT_W
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt      [NUM_REGS];
  logic [CNT_W-1:0]    cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] inc, dec_wb, dec_kill, zero_next, underflow;
  logic                accept, hazard_rs1, hazard_rs2, hazard_rd;
  logic [15:0]         total_next;

  function automatic logic [7:0] sat_u8(input logic [15:0] v);
    return (v > 16'd255) ? 8'hFF : v[7:0];
  endfunction

  // Decrements are decoded apart from inc so the stall path never sees accept.
  always_comb begin
    dec_wb   = '0;
    dec_kill = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      dec_wb[r]   = sb.wb_valid && sb.wb_reg_write && (int'(sb.wb_rd) == r);
      dec_kill[r] = sb.kill_valid && sb.kill_reg_write && (int'(sb.kill_rd) == r);
    end
  end

  assign hazard_rs1 = sb.issue_use_rs1 && (sb.issue_rs1 != '0) &&
                      (cnt[sb.issue_rs1] != '0) && !zero_next[sb.issue_rs1];
  assign hazard_rs2 = sb.issue_use_rs2 && (sb.issue_rs2 != '0) &&
                      (cnt[sb.issue_rs2] != '0) && !zero_next[sb.issue_rs2];
  assign hazard_rd  = sb.issue_reg_write && (sb.issue_rd != '0) &&
                      (cnt[sb.issue_rd] == CNT_MAX) &&
                      !(dec_wb[sb.issue_rd] || dec_kill[sb.issue_rd]);

  assign sb.issue_stall = !rst && sb.issue_valid && (hazard_rs1 || hazard_rs2 || hazard_rd);
  assign accept         = sb.issue_valid && !sb.issue_stall;

  always_comb begin
    inc = '0;
    for (int r = 1; r < NUM_REGS; r++)
      inc[r] = accept && sb.issue_reg_write && (int'(sb.issue_rd) == r);
  end

  // x0 is hardwired: no counter is built for it.
  assign cnt[0]       = '0;
  assign cnt_next[0]  = '0;
  assign zero_next[0] = 1'b0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[r]),
      .dec_wb    (dec_wb[r]),
      .dec_kill  (dec_kill[r]),
      .cnt       (cnt[r]),
      .cnt_next  (cnt_next[r]),
      .zero_next (zero_next[r]),
      .underflow (underflow[r])
    );
  end

  always_comb begin
    total_next = '0;
    for (int r = 0; r < NUM_REGS; r++)
      total_next = total_next + 16'(cnt_next[r]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb.busy_vec    <= '0;
      sb.outstanding <= '0;
      sb.sb_err      <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        sb.busy_vec[r] <= (cnt_next[r] != '0);
      sb.outstanding <= sat_u8(total_next);
      if (|underflow) sb.sb_err <= 1'b1;
    end
  end

endmodule
